fft_bitrev_reorder: RTL

FFT_BITREV_REORDER -- requirements
Module: fft_bitrev_reorder

---
 rtl/fft_bitrev_reorder_pkg.sv | 43 ++++
 rtl/fft_reorder_ram.sv | 36 +++
 rtl/fft_bitrev_reorder.sv | 160 ++++++++++++++++
 3 files changed

// File: rtl/fft_bitrev_reorder_pkg.sv
// ---------------------------------------------------------------------------
// fft_bitrev_reorder_pkg
// Shared definitions for the FFT output reorder stage and any other stage
// that needs to work in bit-reversed address order.
//   DATA_IN_WIDTH     : default width of each real/imaginary sample
//   C2LOG_FFT_POINTS  : default log2 of the FFT frame length
//   rdState_t         : read-side state encoding of the reorder buffer
//   bitrev()          : reverses the low nbits bits of a value
// Each macro keeps any value already supplied on the command line.
// ---------------------------------------------------------------------------
`ifndef DATA_IN_WIDTH
`define DATA_IN_WIDTH 16
`endif
`ifndef C2LOG_FFT_POINTS
`define C2LOG_FFT_POINTS 3
`endif

package fft_bitrev_reorder_pkg;

  // Widest index bitrev() handles; callers cast the result down to their width
  localparam int BITREV_MAX_BITS = 16;

  typedef enum logic {
    RD_IDLE = 1'b0,
    RD_READ = 1'b1
  } rdState_t;

  // Reverses bits [nbits-1:0] of value; bits at and above nbits return 0.
  // The loop bound is fixed, so the function synthesizes to pure wiring
  // when nbits is a constant.
  function automatic logic [BITREV_MAX_BITS-1:0] bitrev(
    input logic [BITREV_MAX_BITS-1:0] value,
    input int                         nbits
  );
    logic [BITREV_MAX_BITS-1:0] result;
    result = '0;
    for (int i = 0; i < BITREV_MAX_BITS; i++) begin
      if (i < nbits) result[i] = value[nbits-1-i];
    end
    return result;
  endfunction

endpackage

// File: rtl/fft_reorder_ram.sv
// ---------------------------------------------------------------------------
// fft_reorder_ram
// Simple dual-port storage for the reorder ping/pong banks. It has one write
// port and one read port with a registered (synchronous) read. The contents
// have no reset.
//   clk        : clock, rising edge
//   i_wrEn     : write strobe
//   i_wrAddr   : write address {bank, entry}
//   i_wrData   : write data {re, im}
//   i_rdEn     : read strobe; o_rdData updates on the next edge
//   i_rdAddr   : read address {bank, entry}
//   o_rdData   : registered read data {re, im}
// ---------------------------------------------------------------------------
module fft_reorder_ram #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              i_wrEn,
  input  logic [ADDR_W-1:0] i_wrAddr,
  input  logic [DATA_W-1:0] i_wrData,
  input  logic              i_rdEn,
  input  logic [ADDR_W-1:0] i_rdAddr,
  output logic [DATA_W-1:0] o_rdData
);

  logic [DATA_W-1:0] r_mem [0:(1<<ADDR_W)-1];

  // Write and registered read share one edge. Any read-during-write to the
  // same address is avoided by the caller's bank scheduling.
  always_ff @(posedge clk) begin
    if (i_wrEn) r_mem[i_wrAddr] <= i_wrData;
    if (i_rdEn) o_rdData <= r_mem[i_rdAddr];
  end

endmodule

// File: rtl/fft_bitrev_reorder.sv
// ---------------------------------------------------------------------------
// fft_bitrev_reorder
// Converts the bit-reversed output order of an FFT pipeline to natural order.
// Samples are written at bitrev(wcnt) into one of two ping/pong banks. Each
// full bank is then read linearly and output with its natural bin index.
//   clk      : clock, rising edge
//   rstn     : asynchronous active-low reset
//   di_en    : input sample valid (a low cycle discards any partial frame)
//   di_re/im : bit-reversed-order sample, WIDTH bits each
//   do_en    : natural-order output valid
//   do_re/im : natural-order sample, forced to 0 while do_en is low
//   do_idx   : natural bin index of the current output, 0 while do_en is low
//   err      : only when FFT_REORDER_ERR_EN is defined; one-cycle pulse
//              after a partial frame is discarded
// Optional build macro: FFT_REORDER_ERR_EN
// ---------------------------------------------------------------------------
`ifndef DATA_IN_WIDTH
`define DATA_IN_WIDTH 16
`endif
`ifndef C2LOG_FFT_POINTS
`define C2LOG_FFT_POINTS 3
`endif

module fft_bitrev_reorder
  import fft_bitrev_reorder_pkg::*;
#(
  parameter int LOG_N = `C2LOG_FFT_POINTS,
  parameter int WIDTH = `DATA_IN_WIDTH
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             di_en,
  input  logic [WIDTH-1:0] di_re,
  input  logic [WIDTH-1:0] di_im,
  output logic             do_en,
  output logic [WIDTH-1:0] do_re,
  output logic [WIDTH-1:0] do_im,
  output logic [LOG_N-1:0] do_idx
`ifdef FFT_REORDER_ERR_EN
  ,
  output logic             err
`endif
);

  logic [LOG_N-1:0]   r_wrCnt;
  logic               r_wrBank;
  logic [1:0]         r_full;
  rdState_t           r_rdState;
  logic [LOG_N-1:0]   r_rdCnt;
  logic               r_rdBank;
  logic               r_doEn;
  logic [LOG_N-1:0]   r_doIdx;

  logic [LOG_N-1:0]   w_wrRev;
  logic [LOG_N:0]     w_wrAddr;
  logic [LOG_N:0]     w_rdAddr;
  logic               w_rdEn;
  logic               w_frameDone;
  logic               w_readDone;
  logic [2*WIDTH-1:0] w_rdData;

  assign w_wrRev     = LOG_N'(bitrev(BITREV_MAX_BITS'(r_wrCnt), LOG_N));
  assign w_wrAddr    = {r_wrBank, w_wrRev};
  assign w_rdAddr    = {r_rdBank, r_rdCnt};
  assign w_rdEn      = (r_rdState == RD_READ);
  assign w_frameDone = di_en && (&r_wrCnt);
  assign w_readDone  = w_rdEn && (&r_rdCnt);

  fft_reorder_ram #(
    .ADDR_W (LOG_N + 1),
    .DATA_W (2 * WIDTH)
  ) u_ram (
    .clk      (clk),
    .i_wrEn   (di_en),
    .i_wrAddr (w_wrAddr),
    .i_wrData ({di_re, di_im}),
    .i_rdEn   (w_rdEn),
    .i_rdAddr (w_rdAddr),
    .o_rdData (w_rdData)
  );

  // Write side: the counter wraps from N-1 back to 0 and the bank flips when
  // a frame completes. A low di_en drops the partial frame, and the next frame
  // restarts at entry 0 of the same bank.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_wrCnt  <= '0;
      r_wrBank <= 1'b0;
    end else if (di_en) begin
      r_wrCnt <= r_wrCnt + LOG_N'(1);
      if (w_frameDone) r_wrBank <= ~r_wrBank;
    end else begin
      r_wrCnt <= '0;
    end
  end

  // The writer sets the full flags and the reader clears them. The set is
  // written last, although at one sample per cycle the two never target the
  // same bank on the same edge.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_full <= '0;
    end else begin
      if (w_readDone)  r_full[r_rdBank] <= 1'b0;
      if (w_frameDone) r_full[r_wrBank] <= 1'b1;
    end
  end

  // Read FSM. Frames fill the banks alternately, so the reader only needs to
  // follow its own bank pointer. On the last entry it chains directly into
  // the other bank when that bank is already full, which keeps do_en gapless
  // for back-to-back frames. do_en/do_idx are registered to line up with the
  // synchronous RAM read data.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_rdState <= RD_IDLE;
      r_rdCnt   <= '0;
      r_rdBank  <= 1'b0;
      r_doEn    <= 1'b0;
      r_doIdx   <= '0;
    end else begin
      r_doEn  <= w_rdEn;
      r_doIdx <= w_rdEn ? r_rdCnt : '0;
      case (r_rdState)
        RD_IDLE: begin
          r_rdCnt <= '0;
          if (r_full[r_rdBank]) r_rdState <= RD_READ;
        end
        RD_READ: begin
          r_rdCnt <= r_rdCnt + LOG_N'(1);
          if (&r_rdCnt) begin
            r_rdBank <= ~r_rdBank;
            if (!r_full[~r_rdBank]) r_rdState <= RD_IDLE;
          end
        end
        default: r_rdState <= RD_IDLE;
      endcase
    end
  end

  assign do_en  = r_doEn;
  assign do_idx = r_doIdx;
  assign do_re  = r_doEn ? w_rdData[2*WIDTH-1:WIDTH] : '0;
  assign do_im  = r_doEn ? w_rdData[WIDTH-1:0]       : '0;

`ifdef FFT_REORDER_ERR_EN
  logic r_err;

  // A nonzero write count when di_en drops means a partial frame was just
  // discarded. The counter is already zero one cycle later, so the flag
  // pulses for a single cycle.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) r_err <= 1'b0;
    else       r_err <= !di_en && (r_wrCnt != '0);
  end

  assign err = r_err;
`endif

endmodule
